// File: rtl/game_pkg.sv
// Shared game constants, gamemode encodings and the trail sequencer state type.
package game_pkg;

  localparam int unsigned NUM_TRAIL       = 41;
  localparam int unsigned SPAWN_PER_FRAME = 5;
  localparam logic [3:0]  LIFE_INIT       = 4'd10;
  localparam int unsigned PLAYER_X        = 200;
  localparam int unsigned PLAYER_SIZE     = 40;
  localparam int unsigned SPREAD          = 8;
  localparam int unsigned SCREEN_H        = 480;

  localparam logic [1:0] GM_MENU = 2'b00;
  localparam logic [1:0] GM_PLAY = 2'b01;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DECAY = 2'd2,
    SPAWN = 2'd3
  } trail_state_t;

endpackage

// File: rtl/trail_ctrl_if.sv
// Frame control inputs and registered particle arrays between game logic and the trail engine.
interface trail_ctrl_if #(
  parameter int unsigned NUM_TRAIL = game_pkg::NUM_TRAIL
);
  logic                       frame_tick;
  logic [1:0]                 gamemode;
  logic [8:0]                 player_y;
  logic [NUM_TRAIL-1:0][9:0]  trail_x;
  logic [NUM_TRAIL-1:0][8:0]  trail_y;
  logic [NUM_TRAIL-1:0][3:0]  trail_life;
  logic                       busy;

  modport master (
    output frame_tick, gamemode, player_y,
    input  trail_x, trail_y, trail_life, busy
  );

  modport slave (
    input  frame_tick, gamemode, player_y,
    output trail_x, trail_y, trail_life, busy
  );
endinterface

// File: rtl/trail_ctrl.sv
// Per-frame trail particle sequencer: clears on menu frames, decays and spawns on play frames,
// touching one slot per cycle.
import game_pkg::*;

module trail_ctrl #(
  parameter int unsigned NUM_TRAIL       = game_pkg::NUM_TRAIL,
  parameter int unsigned SPAWN_PER_FRAME = game_pkg::SPAWN_PER_FRAME,
  parameter logic [3:0]  LIFE_INIT       = game_pkg::LIFE_INIT,
  parameter int unsigned PLAYER_X        = game_pkg::PLAYER_X,
  parameter int unsigned PLAYER_SIZE     = game_pkg::PLAYER_SIZE,
  parameter int unsigned SPREAD          = game_pkg::SPREAD
) (
  input  logic        clk,
  input  logic        rst,
  trail_ctrl_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_TRAIL > 1) ? $clog2(NUM_TRAIL) : 1;
  localparam int unsigned K_W   = (SPAWN_PER_FRAME > 1) ? $clog2(SPAWN_PER_FRAME) : 1;

  trail_state_t state, next_state;

  logic [IDX_W-1:0]          idx;
  logic [IDX_W-1:0]          wr_ptr;
  logic [K_W-1:0]            k;
  logic [8:0]                latched_y;
  logic [NUM_TRAIL-1:0][9:0] x_q;
  logic [NUM_TRAIL-1:0][8:0] y_q;
  logic [NUM_TRAIL-1:0][3:0] life_q;

  logic              accept;
  logic              last_idx;
  logic              last_k;
  logic signed [10:0] k_off;
  logic signed [10:0] y_raw;
  logic [8:0]         spawn_y;

  assign accept   = bus.frame_tick && (bus.gamemode == GM_MENU || bus.gamemode == GM_PLAY);
  assign last_idx = (idx == IDX_W'(NUM_TRAIL - 1));
  assign last_k   = (k == K_W'(SPAWN_PER_FRAME - 1));

  // Spawn column is centred on the player: offsets run -2..+2 steps of SPREAD.
  always_comb begin
    k_off = $signed(11'(k)) - 11'sd2;
    y_raw = $signed({2'b00, latched_y}) + $signed(11'(PLAYER_SIZE / 2))
          + k_off * $signed(11'(SPREAD));
    if (y_raw < 11'sd0)
      spawn_y = '0;
    else if (y_raw > $signed(11'(SCREEN_H - 1)))
      spawn_y = 9'(SCREEN_H - 1);
    else
      spawn_y = y_raw[8:0];
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.frame_tick) begin
          if (bus.gamemode == GM_MENU)      next_state = CLEAR;
          else if (bus.gamemode == GM_PLAY) next_state = DECAY;
        end
      end
      CLEAR:   if (last_idx) next_state = IDLE;
      DECAY:   if (last_idx) next_state = SPAWN;
      SPAWN:   if (last_k)   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      k         <= '0;
      wr_ptr    <= '0;
      latched_y <= '0;
      x_q       <= '0;
      y_q       <= '0;
      life_q    <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (accept) begin
            latched_y <= bus.player_y;
            idx       <= '0;
            k         <= '0;
          end
        end
        CLEAR: begin
          x_q[idx]    <= '0;
          y_q[idx]    <= '0;
          life_q[idx] <= '0;
          idx         <= last_idx ? '0 : idx + 1'b1;
          if (last_idx) wr_ptr <= '0;
        end
        DECAY: begin
          if (life_q[idx] != 4'd0) life_q[idx] <= life_q[idx] - 4'd1;
          idx <= last_idx ? '0 : idx + 1'b1;
        end
        SPAWN: begin
          x_q[wr_ptr]    <= 10'(PLAYER_X - 5);
          y_q[wr_ptr]    <= spawn_y;
          life_q[wr_ptr] <= LIFE_INIT;
          wr_ptr         <= (wr_ptr == IDX_W'(NUM_TRAIL - 1)) ? '0 : wr_ptr + 1'b1;
          k              <= last_k ? '0 : k + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.trail_x    = x_q;
  assign bus.trail_y    = y_q;
  assign bus.trail_life = life_q;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_trail_ctrl.sv
// Scoreboard bench for trail_ctrl: each frame pushes its expected end-of-frame arrays,
// a monitor pops and compares when busy falls.
module tb_trail_ctrl;
  import game_pkg::*;

  localparam int NT = 41;

  logic clk = 1'b0;
  logic rst;

  trail_ctrl_if #(.NUM_TRAIL(NT)) bus ();

  trail_ctrl #(
    .NUM_TRAIL      (NT),
    .SPAWN_PER_FRAME(5),
    .LIFE_INIT      (4'd10),
    .PLAYER_X       (200),
    .PLAYER_SIZE    (40),
    .SPREAD         (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string               name;
    logic [NT-1:0][9:0]  x;
    logic [NT-1:0][8:0]  y;
    logic [NT-1:0][3:0]  life;
    int                  cycles;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int m_x[NT];
  int m_y[NT];
  int m_life[NT];
  int m_wp = 0;

  task automatic chk(input string n, input logic [511:0] act, input logic [511:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", n, act, want);
    end
  endtask

  function automatic void m_clear();
    for (int i = 0; i < NT; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_life[i] = 0;
    end
    m_wp = 0;
  endfunction

  function automatic void m_decay();
    for (int i = 0; i < NT; i++)
      if (m_life[i] > 0) m_life[i] = m_life[i] - 1;
  endfunction

  function automatic void m_spawn(input int py);
    for (int j = 0; j < 5; j++) begin
      int yy;
      yy = py + 20 + (j - 2) * 8;
      if (yy < 0) yy = 0;
      if (yy > 479) yy = 479;
      m_x[m_wp] = 195;
      m_y[m_wp] = yy;
      m_life[m_wp] = 10;
      m_wp = (m_wp + 1) % NT;
    end
  endfunction

  function automatic exp_t model_snapshot(input string n, input int cyc);
    exp_t e;
    e.name = n;
    e.cycles = cyc;
    for (int i = 0; i < NT; i++) begin
      e.x[i]    = 10'(m_x[i]);
      e.y[i]    = 9'(m_y[i]);
      e.life[i] = 4'(m_life[i]);
    end
    return e;
  endfunction

  task automatic push_exp(input string n, input int cyc);
    sb.push_back(model_snapshot(n, cyc));
  endtask

  task automatic cmp_model(input string n);
    exp_t e;
    e = model_snapshot(n, 0);
    chk({n, "_x"},    512'(bus.trail_x),    512'(e.x));
    chk({n, "_y"},    512'(bus.trail_y),    512'(e.y));
    chk({n, "_life"}, 512'(bus.trail_life), 512'(e.life));
  endtask

  // Monitor: a completed (or aborted) sequence is presented by busy falling.
  initial begin
    logic prev_busy;
    int   run_len;
    exp_t e;
    prev_busy = 1'b0;
    run_len = 0;
    forever begin
      @(negedge clk);
      if (bus.busy === 1'b1) run_len++;
      if (prev_busy === 1'b1 && bus.busy === 1'b0) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_seq: got busy run of %0d cycles want none", run_len);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_x"},    512'(bus.trail_x),    512'(e.x));
          chk({e.name, "_y"},    512'(bus.trail_y),    512'(e.y));
          chk({e.name, "_life"}, 512'(bus.trail_life), 512'(e.life));
          if (e.cycles >= 0) chk({e.name, "_busy_len"}, 512'(run_len), 512'(e.cycles));
        end
        run_len = 0;
      end
      prev_busy = bus.busy;
    end
  end

  task automatic frame(input logic [1:0] gm, input logic [8:0] py);
    bus.gamemode = gm;
    bus.player_y = py;
    @(posedge clk); #1;
    bus.frame_tick = 1'b1;
    @(posedge clk); #1;
    bus.frame_tick = 1'b0;
    bus.player_y = 9'h1FF;
  endtask

  task automatic wait_idle(input string n);
    int cnt;
    cnt = 0;
    while (bus.busy !== 1'b0 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 200) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got busy after %0d cycles want idle", n, cnt);
    end
    @(negedge clk);
  endtask

  task automatic play(input int py, input string n);
    m_decay();
    m_spawn(py);
    push_exp(n, 46);
    frame(GM_PLAY, 9'(py));
    wait_idle(n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_busy;
    m_clear();
    rst = 1'b1;
    bus.frame_tick = 1'b1;
    bus.gamemode = GM_PLAY;
    bus.player_y = 9'd200;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.frame_tick = 1'b0;
    @(negedge clk);
    chk("rst_busy", 512'(bus.busy), 512'(0));
    chk("rst_life", 512'(bus.trail_life), 512'(0));
    cmp_model("rst_arrays");
    repeat (3) @(negedge clk);
    chk("rst_tick_ignored", 512'(bus.busy), 512'(0));

    // First play frame: slots 0..4 around player_y=200.
    play(200, "play1");
    chk("p1_x0", 512'(bus.trail_x[0]), 512'(195));
    chk("p1_y0", 512'(bus.trail_y[0]), 512'(204));
    chk("p1_y1", 512'(bus.trail_y[1]), 512'(212));
    chk("p1_y2", 512'(bus.trail_y[2]), 512'(220));
    chk("p1_y3", 512'(bus.trail_y[3]), 512'(228));
    chk("p1_y4", 512'(bus.trail_y[4]), 512'(236));
    chk("p1_life4", 512'(bus.trail_life[4]), 512'(10));
    chk("p1_life5", 512'(bus.trail_life[5]), 512'(0));

    play(200, "play2");
    chk("p2_life40_zero", 512'(bus.trail_life[40]), 512'(0));
    chk("p2_life0", 512'(bus.trail_life[0]), 512'(9));
    for (int f = 3; f <= 9; f++) play(200, $sformatf("play%0d", f));
    for (int s = 0; s < 4; s++)
      chk($sformatf("wrap_life%0d", s), 512'(bus.trail_life[s]), 512'(10));
    chk("wrap_life4", 512'(bus.trail_life[4]), 512'(2));

    // Clamp at the bottom edge, then the top edge.
    play(470, "clamp_hi");
    chk("chi_y4", 512'(bus.trail_y[4]), 512'(474));
    for (int s = 5; s <= 8; s++)
      chk($sformatf("chi_y%0d", s), 512'(bus.trail_y[s]), 512'(479));
    play(0, "clamp_lo");
    chk("clo_y9",  512'(bus.trail_y[9]),  512'(4));
    chk("clo_y10", 512'(bus.trail_y[10]), 512'(12));
    chk("clo_y11", 512'(bus.trail_y[11]), 512'(20));
    chk("clo_y12", 512'(bus.trail_y[12]), 512'(28));
    chk("clo_y13", 512'(bus.trail_y[13]), 512'(36));

    // Tick while busy is dropped; gamemode change mid-run leaves the run alone.
    m_decay();
    m_spawn(100);
    push_exp("busy_drop", 46);
    frame(GM_PLAY, 9'd100);
    repeat (9) @(posedge clk);
    #1 bus.frame_tick = 1'b1;
    @(posedge clk);
    #1 bus.frame_tick = 1'b0;
    repeat (9) @(posedge clk);
    #1 bus.gamemode = GM_MENU;
    wait_idle("busy_drop");
    saw_busy = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.busy === 1'b1) saw_busy = 1'b1;
    end
    chk("no_queued_tick", 512'(saw_busy), 512'(0));

    // Frozen modes: no sequence, no array change.
    for (int g = 2; g <= 3; g++) begin
      frame(2'(g), 9'd50);
      saw_busy = 1'b0;
      repeat (5) begin
        @(negedge clk);
        if (bus.busy === 1'b1) saw_busy = 1'b1;
      end
      chk($sformatf("freeze%0d_busy", g), 512'(saw_busy), 512'(0));
      cmp_model($sformatf("freeze%0d", g));
    end

    // Menu frame clears everything and rewinds the write pointer.
    m_clear();
    push_exp("menu", 41);
    frame(GM_MENU, 9'd0);
    wait_idle("menu");
    play(100, "after_menu");
    chk("am_y0", 512'(bus.trail_y[0]), 512'(104));
    chk("am_life5", 512'(bus.trail_life[5]), 512'(0));

    // Reset during DECAY aborts and clears; next frame starts from slot 0.
    m_clear();
    push_exp("abort", -1);
    frame(GM_PLAY, 9'd200);
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 512'(bus.busy), 512'(0));
    cmp_model("abort_arrays");
    @(negedge clk);
    play(300, "after_abort");
    chk("aa_y0", 512'(bus.trail_y[0]), 512'(304));
    chk("aa_life0", 512'(bus.trail_life[0]), 512'(10));
    chk("aa_life5", 512'(bus.trail_life[5]), 512'(0));

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 512'(sb.size()), 512'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trail_ctrl.md
TRAIL_CTRL -- requirements
Module: trail_ctrl

Interface
REQ-001 Parameter: NUM_TRAIL, 41, number of trail particle slots.
REQ-002 Parameter: SPAWN_PER_FRAME, 5, particles emitted per play frame.
REQ-003 Parameter: LIFE_INIT, 4'd10, life loaded into a newly spawned particle.
REQ-004 Parameter: PLAYER_X, 200, player left edge in pixels; PLAYER_SIZE, 40, player side length in pixels.
REQ-005 Parameter: SPREAD, 8, vertical pixel spacing between particles spawned in one frame.
REQ-006 Port: clk  input  1  system clock; single clock domain.
REQ-007 Port: rst  input  1  reset, synchronous and active-high.
REQ-008 Port: frame_tick  input  1  one-cycle pulse at start of vertical blank.
REQ-009 Port: gamemode  input  2  00 = menu, 01 = play, 10/11 = frozen.
REQ-010 Port: player_y  input  9  player top edge in pixels.
REQ-011 Port: trail_x  output  [NUM_TRAIL-1:0][9:0]  particle x, packed array, registered.
REQ-012 Port: trail_y  output  [NUM_TRAIL-1:0][8:0]  particle y, packed array, registered.
REQ-013 Port: trail_life  output  [NUM_TRAIL-1:0][3:0]  particle life; 0 = slot inactive (renderer draws nothing).
REQ-014 Port: busy  output  1  high whenever FSM is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, CLEAR, DECAY, SPAWN.
REQ-016 IDLE + frame_tick + gamemode==00 -> CLEAR; gamemode==01 -> DECAY; gamemode 10/11 -> stay IDLE, no array change.
REQ-017 On accepting a tick, player_y SHALL be latched; SPAWN uses only the latched value.
REQ-018 CLEAR: slot index idx 0..NUM_TRAIL-1, one slot per cycle, x/y/life <= 0; after last slot wr_ptr <= 0 and -> IDLE.
REQ-019 DECAY: idx 0..NUM_TRAIL-1, one slot per cycle; life>0 -> life-1; life==0 unchanged (no underflow); after last slot -> SPAWN.
REQ-020 SPAWN: k 0..SPAWN_PER_FRAME-1, one per cycle, write slot wr_ptr: x = PLAYER_X-5, y = latched_y + PLAYER_SIZE/2 + (k-2)*SPREAD, life = LIFE_INIT; wr_ptr increments.
REQ-021 y computed at 11-bit signed width; result <0 clamps to 0, >479 clamps to 479.
REQ-022 wr_ptr wraps NUM_TRAIL-1 -> 0; oldest particle is overwritten regardless of its life.
REQ-023 After SPAWN k==SPAWN_PER_FRAME-1 -> IDLE.
REQ-024 Latency: play frame busy for exactly NUM_TRAIL+SPAWN_PER_FRAME = 46 cycles; menu frame busy for NUM_TRAIL = 41 cycles.
REQ-025 frame_tick while busy SHALL be ignored (dropped, not queued); gamemode changes mid-sequence SHALL not alter the running sequence.
REQ-026 Outputs change only for the slot addressed in the current cycle; all other slots hold.

Reset
REQ-027 rst SHALL, on the clock edge, force state IDLE, idx 0, k 0, wr_ptr 0, busy 0, and every trail_x/trail_y/trail_life entry 0.
REQ-028 rst asserted mid-sequence SHALL abort it; the next accepted tick starts a fresh sequence.
REQ-029 rst SHALL dominate frame_tick in the same cycle.

Structure
REQ-030 Shared package game_pkg SHALL hold NUM_TRAIL, LIFE_INIT, PLAYER_X, PLAYER_SIZE, screen height 480, gamemode encodings, and the trail_state_t enum.
REQ-031 No sub-module; single module, one FSM and counter datapath.

Verification
REQ-032 Reset: after rst, all 41 life entries read 0 and busy = 0; a frame_tick asserted together with rst is ignored.
REQ-033 Play frame: gamemode=01, player_y=200, tick -> busy for 46 cycles; slots 0..4 hold x=195, y=204/212/220/228/236, life=10; wr_ptr=5.
REQ-034 Decay/wrap: 9 play ticks -> wr_ptr=45 mod 41=4; slots 0..3 overwritten with life 10; slot 4 = life 2; zero-life slots stay 0.
REQ-035 Clamp: player_y=470, tick -> y values 474, 479, 479, 479, 479; player_y=0 -> y 4, 12, 20, 28, 36.
REQ-036 Busy drop and freeze: tick at cycle 10 of a sequence ignored (only one decay applied); gamemode=10 tick -> arrays unchanged, busy stays 0.
REQ-037 Menu and abort: gamemode=00 tick -> after 41 cycles all slots zero and wr_ptr 0; rst at DECAY cycle 20 -> immediate full clear, IDLE.
